// File: rtl/fetch_stage_pkg.sv
// Shared constants for the ECE352 pipeline front end: widths, the opcode field
// position and the STOP encoding. Decode imports the same package.
package fetch_stage_pkg;

    localparam int unsigned PC_WIDTH_DEF    = 8;
    localparam int unsigned INSTR_WIDTH_DEF = 8;
    localparam int unsigned CNT_WIDTH_DEF   = 16;

    localparam int unsigned OPCODE_MSB = 3;
    localparam int unsigned OPCODE_LSB = 0;

    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_STOP = 4'b0001;

    typedef enum logic [1:0] {
        PC_SEL_REDIRECT,
        PC_SEL_HOLD,
        PC_SEL_INCR
    } pc_sel_e;

    function automatic logic is_stop(input logic [OPCODE_MSB:OPCODE_LSB] opcode);
        return opcode == OPCODE_STOP;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// Pipeline register carrying {valid, instr, pc}; flush beats stall, and a flush
// only clears valid so the payload stays stable for debug visibility.
module ifid_reg #(
    parameter int unsigned INSTR_WIDTH = 8,
    parameter int unsigned PC_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   stall_i,
    input  logic                   valid_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic                   valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    pc_o
);

    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc_q,    pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!stall_i) begin
            valid_d = valid_i;
            instr_d = instr_i;
            pc_d    = pc_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the synchronous instruction-memory address,
// handles stall, branch redirect and STOP, and fills the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = PC_WIDTH_DEF,
    parameter int unsigned          INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned          CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   ifid_valid_o,
    output logic [INSTR_WIDTH-1:0] ifid_instr_o,
    output logic [PC_WIDTH-1:0]    ifid_pc_o,
    output logic                   halted_o,
    output logic [CNT_WIDTH-1:0]   fetch_count_o
);

    // pc_q is the address whose data is on imem_rdata_i this cycle
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic                 rd_valid_q;
    logic                 halted_q, halted_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    pc_sel_e              pc_sel;
    logic                 capture;
    logic                 write_valid;
    logic                 deliver;

    always_comb begin
        pc_sel = PC_SEL_INCR;
        if (redirect_i) begin
            pc_sel = PC_SEL_REDIRECT;
        end else if (stall_i || halted_q || !rd_valid_q) begin
            pc_sel = PC_SEL_HOLD;
        end

        case (pc_sel)
            PC_SEL_REDIRECT: pc_d = redirect_pc_i;
            PC_SEL_HOLD:     pc_d = pc_q;
            default:         pc_d = pc_q + PC_WIDTH'(1);
        endcase

        capture     = !redirect_i && !stall_i;
        write_valid = rd_valid_q && !halted_q;
        deliver     = capture && write_valid;

        halted_d = halted_q;
        if (redirect_i) begin
            halted_d = 1'b0;
        end else if (deliver && is_stop(imem_rdata_i[OPCODE_MSB:OPCODE_LSB])) begin
            halted_d = 1'b1;
        end

        count_d = count_q;
        if (deliver && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            rd_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            rd_valid_q <= 1'b1;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    ifid_reg #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .PC_WIDTH    (PC_WIDTH)
    ) u_ifid (
        .clock   (clock),
        .reset   (reset),
        .flush_i (redirect_i),
        .stall_i (stall_i),
        .valid_i (write_valid),
        .instr_i (imem_rdata_i),
        .pc_i    (pc_q),
        .valid_o (ifid_valid_o),
        .instr_o (ifid_instr_o),
        .pc_o    (ifid_pc_o)
    );

    assign imem_addr_o   = pc_d;
    assign halted_o      = halted_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (RESET_PC 0 and 8'hFE) sharing
// one synchronous instruction memory model.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall, redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  addr_m, rdata_m, instr_m, pc_m;
    logic        valid_m, halted_m;
    logic [15:0] count_m;

    logic        stall_f, redirect_f;
    logic [7:0]  redirect_pc_f;
    logic [7:0]  addr_f, rdata_f, instr_f, pc_f;
    logic        valid_f, halted_f;
    logic [15:0] count_f;

    logic [7:0]  mem [256];
    int          checks;
    int          failures;

    fetch_stage #(.PC_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (addr_m),
        .imem_rdata_i  (rdata_m),
        .ifid_valid_o  (valid_m),
        .ifid_instr_o  (instr_m),
        .ifid_pc_o     (pc_m),
        .halted_o      (halted_m),
        .fetch_count_o (count_m)
    );

    fetch_stage #(.PC_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(8'hFE), .CNT_WIDTH(16)) dut_fe (
        .clock         (clock),
        .reset         (reset),
        .stall_i       (stall_f),
        .redirect_i    (redirect_f),
        .redirect_pc_i (redirect_pc_f),
        .imem_addr_o   (addr_f),
        .imem_rdata_i  (rdata_f),
        .ifid_valid_o  (valid_f),
        .ifid_instr_o  (instr_f),
        .ifid_pc_o     (pc_f),
        .halted_o      (halted_f),
        .fetch_count_o (count_f)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        rdata_m <= mem[addr_m];
        rdata_f <= mem[addr_f];
    end

    // Default memory image: low nibble is never 4'b0001, so nothing halts by accident.
    function automatic logic [7:0] pat(input logic [7:0] a);
        return {a[5:0], 2'b10};
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 8'h00;
        stall_f       = 1'b0;
        redirect_f    = 1'b0;
        redirect_pc_f = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));

        // reset state
        tick();
        tick();
        chk1 ("rst_valid",  valid_m,  1'b0);
        chk8 ("rst_instr",  instr_m,  8'h00);
        chk8 ("rst_pc",     pc_m,     8'h00);
        chk1 ("rst_halted", halted_m, 1'b0);
        chk16("rst_count",  count_m,  16'd0);
        chk8 ("rst_addr",   addr_m,   8'h00);
        chk8 ("rst_addr_fe", addr_f,  8'hFE);

        // free run: first valid on the 2nd edge after release
        reset = 1'b1;
        tick();
        chk1 ("lat_edge1_valid", valid_m, 1'b0);
        tick();
        chk1 ("lat_edge2_valid", valid_m, 1'b1);
        chk8 ("lat_edge2_instr", instr_m, pat(8'h00));
        chk8 ("lat_edge2_pc",    pc_m,    8'h00);
        chk16("lat_edge2_count", count_m, 16'd1);
        chk8 ("fe_first_pc",     pc_f,    8'hFE);
        chk8 ("fe_first_instr",  instr_f, pat(8'hFE));
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk1 ("run_valid", valid_m, 1'b1);
            chk8 ("run_pc",    pc_m,    8'(k));
            chk8 ("run_instr", instr_m, pat(8'(k)));
            if (k <= 3) begin
                chk8 ("fe_wrap_pc",   pc_f,     8'hFE + 8'(k));
                chk8 ("fe_wrap_instr", instr_f, pat(8'hFE + 8'(k)));
                chk1 ("fe_halted",    halted_f, 1'b0);
                chk16("fe_count",     count_f,  16'(k + 1));
            end
        end
        chk16("run_count", count_m, 16'd6);

        // stall for 3 cycles while IF/ID holds pc 5
        stall = 1'b1;
        #1;
        chk8("stall_addr_now", addr_m, 8'h06);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1 ("stall_valid", valid_m, 1'b1);
            chk8 ("stall_pc",    pc_m,    8'h05);
            chk8 ("stall_instr", instr_m, pat(8'h05));
            chk8 ("stall_addr",  addr_m,  8'h06);
            chk16("stall_count", count_m, 16'd6);
        end
        stall = 1'b0;
        tick();
        chk8 ("unstall_pc6",   pc_m,    8'h06);
        chk8 ("unstall_instr", instr_m, pat(8'h06));
        tick();
        chk8 ("unstall_pc7",   pc_m,    8'h07);
        chk16("unstall_count", count_m, 16'd8);

        // redirect to 0x40 with stall also asserted: redirect wins
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        #1;
        chk8("redir_addr", addr_m, 8'h40);
        @(negedge clock);
        tick();
        chk1 ("redir_bubble_valid", valid_m, 1'b0);
        chk8 ("redir_bubble_pc",    pc_m,    8'h07);
        chk16("redir_bubble_count", count_m, 16'd8);
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        chk1 ("redir_tgt_valid", valid_m, 1'b1);
        chk8 ("redir_tgt_pc",    pc_m,    8'h40);
        chk8 ("redir_tgt_instr", instr_m, pat(8'h40));
        tick();
        chk8 ("redir_next_pc",   pc_m,    8'h41);
        chk16("redir_count10",   count_m, 16'd10);

        // asynchronous reset mid-stream after 10 fetches
        #2;
        reset = 1'b0;
        #1;
        chk1 ("arst_valid",  valid_m,  1'b0);
        chk8 ("arst_instr",  instr_m,  8'h00);
        chk8 ("arst_pc",     pc_m,     8'h00);
        chk1 ("arst_halted", halted_m, 1'b0);
        chk16("arst_count",  count_m,  16'd0);
        chk8 ("arst_addr",   addr_m,   8'h00);
        @(negedge clock);
        mem[3] = 8'hF1;
        reset  = 1'b1;
        tick();
        chk1 ("rerun_edge1_valid", valid_m, 1'b0);
        tick();
        chk1 ("rerun_edge2_valid", valid_m, 1'b1);
        chk8 ("rerun_edge2_pc",    pc_m,    8'h00);
        chk8 ("rerun_edge2_instr", instr_m, pat(8'h00));

        // STOP at mem[3]
        tick();
        tick();
        chk8 ("pre_stop_pc",  pc_m,     8'h02);
        chk1 ("pre_stop_hlt", halted_m, 1'b0);
        tick();
        chk1 ("stop_valid",  valid_m,  1'b1);
        chk8 ("stop_pc",     pc_m,     8'h03);
        chk8 ("stop_instr",  instr_m,  8'hF1);
        chk1 ("stop_halted", halted_m, 1'b1);
        chk16("stop_count",  count_m,  16'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1 ("halt_valid",  valid_m,  1'b0);
            chk1 ("halt_halted", halted_m, 1'b1);
            chk16("halt_count",  count_m,  16'd4);
            chk8 ("halt_addr",   addr_m,   8'h04);
        end

        // redirect out of halt
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        #1;
        chk8("resume_addr",       addr_m,   8'h20);
        chk1("resume_pre_halted", halted_m, 1'b1);
        @(negedge clock);
        tick();
        chk1("resume_bubble_valid", valid_m,  1'b0);
        chk1("resume_halted_clr",   halted_m, 1'b0);
        redirect = 1'b0;
        tick();
        chk1 ("resume_valid", valid_m, 1'b1);
        chk8 ("resume_pc",    pc_m,    8'h20);
        chk8 ("resume_instr", instr_m, pat(8'h20));
        chk16("resume_count", count_m, 16'd5);
        tick();
        chk8 ("resume_next_pc", pc_m,    8'h21);
        chk16("resume_count6",  count_m, 16'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
